// File: rtl/misaligned_mem_seq_pkg.sv
// Shared constants, state encoding and helpers for the misaligned memory sequencer.
// Covers RV32I load/store funct3 codes and the misaligned-access test.
package misaligned_mem_seq_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SPLIT = 1'b1
    } seq_state_e;

    // Halfwords need an even address and words need a 4-byte-aligned address.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        case (f3)
            F3_H, F3_HU: mis = addr_lo[0];
            F3_W:        mis = (addr_lo != 2'b00);
            default:     mis = 1'b0;
        endcase
        return mis;
    endfunction

    // Index of the final byte in a split access (N-1).
    function automatic logic [1:0] last_idx(input logic [2:0] f3);
        logic [1:0] li;
        case (f3)
            F3_W:    li = 2'd3;
            default: li = 2'd1;
        endcase
        return li;
    endfunction

endpackage

// File: rtl/misaligned_mem_seq_if.sv
// Data-memory bus between the sequencer (master) and the byte-addressable memory (slave).
interface misaligned_mem_seq_if #(
    parameter int ADDR_W = 32
) ();
    logic              MemRead;
    logic              MemWrite;
    logic [2:0]        func3;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data_in;
    logic [31:0]       mem_rdata;

    modport master (
        output MemRead, MemWrite, func3, addr, data_in,
        input  mem_rdata
    );

    modport slave (
        input  MemRead, MemWrite, func3, addr, data_in,
        output mem_rdata
    );
endinterface

// File: rtl/misaligned_mem_seq_load_ext.sv
// Combinational sign/zero extension of a little-endian load word by funct3.
// Illegal funct3 codes leave the word untouched.
module mem_load_ext
    import misaligned_mem_seq_pkg::*;
(
    input  logic [31:0] word,
    input  logic [2:0]  func3,
    output logic [31:0] result
);

    // Select the extension rule for the load width.
    always_comb begin
        result = word;
        case (func3)
            F3_B:    result = {{24{word[7]}}, word[7:0]};
            F3_BU:   result = {24'd0, word[7:0]};
            F3_H:    result = {{16{word[15]}}, word[15:0]};
            F3_HU:   result = {16'd0, word[15:0]};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/misaligned_mem_seq.sv
// MEM-stage front end: aligned accesses pass straight to data memory, misaligned
// halfword/word accesses are split into byte accesses while the pipeline stalls.
module misaligned_mem_seq
    import misaligned_mem_seq_pkg::*;
#(
    parameter bit ALLOW_MISALIGNED = 1'b1,
    parameter int ADDR_W           = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req_read,
    input  logic                        req_write,
    input  logic [2:0]                  req_func3,
    input  logic [ADDR_W-1:0]           req_addr,
    input  logic [31:0]                 req_wdata,
    output logic [31:0]                 rdata,
    output logic                        stall,
    output logic                        misaligned_fault,
    misaligned_mem_seq_if.master        mem
);

    seq_state_e        state_r;
    seq_state_e        state_nxt_s;
    logic [1:0]        idx_r;
    logic [1:0]        idx_nxt_s;
    logic [31:0]       assy_r;
    logic [31:0]       assy_nxt_s;

    logic              rd_s;
    logic              active_s;
    logic              mis_s;
    logic [7:0]        wbyte_s;
    logic [31:0]       assy_cur_s;
    logic [ADDR_W-1:0] byte_addr_s;

    logic              mem_read_s;
    logic              mem_write_s;
    logic [2:0]        mem_func3_s;
    logic [ADDR_W-1:0] mem_addr_s;
    logic [31:0]       mem_wdata_s;
    logic              stall_s;
    logic              fault_s;
    logic              rdata_en_s;
    logic [31:0]       ext_word_s;
    logic [2:0]        ext_func3_s;
    logic [31:0]       ext_out_s;

    // Request decode: a store always wins over a simultaneous load.
    always_comb begin
        rd_s        = req_read & ~req_write;
        active_s    = req_read | req_write;
        mis_s       = is_misaligned(req_func3, req_addr[1:0]);
        wbyte_s     = req_wdata[{idx_r, 3'b000} +: 8];
        byte_addr_s = req_addr + ADDR_W'(idx_r);
        assy_cur_s  = assy_r;
        assy_cur_s[{idx_r, 3'b000} +: 8] = mem.mem_rdata[7:0];
    end

    // Next-state and memory-bus control; reset blanks every access in its cycle.
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = idx_r;
        assy_nxt_s  = assy_r;
        mem_read_s  = 1'b0;
        mem_write_s = 1'b0;
        mem_func3_s = F3_B;
        mem_addr_s  = req_addr;
        mem_wdata_s = 32'd0;
        stall_s     = 1'b0;
        fault_s     = 1'b0;
        rdata_en_s  = 1'b0;
        ext_word_s  = 32'd0;
        ext_func3_s = F3_W;
        if (rst) begin
            state_nxt_s = ST_IDLE;
            idx_nxt_s   = 2'd0;
            assy_nxt_s  = 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (active_s && mis_s) begin
                        if (ALLOW_MISALIGNED) begin
                            mem_read_s  = rd_s;
                            mem_write_s = req_write;
                            mem_func3_s = F3_B;
                            mem_addr_s  = req_addr;
                            mem_wdata_s = {24'd0, req_wdata[7:0]};
                            stall_s     = 1'b1;
                            state_nxt_s = ST_SPLIT;
                            idx_nxt_s   = 2'd1;
                            if (rd_s) begin
                                assy_nxt_s = {24'd0, mem.mem_rdata[7:0]};
                            end else begin
                                assy_nxt_s = 32'd0;
                            end
                        end else begin
                            fault_s = 1'b1;
                        end
                    end else begin
                        mem_read_s  = rd_s;
                        mem_write_s = req_write;
                        mem_func3_s = req_func3;
                        mem_addr_s  = req_addr;
                        mem_wdata_s = req_wdata;
                        rdata_en_s  = rd_s;
                        ext_word_s  = mem.mem_rdata;
                        ext_func3_s = req_func3;
                    end
                end
                ST_SPLIT: begin
                    if (!active_s) begin
                        // Request vanished mid-split: abandon without issuing anything.
                        state_nxt_s = ST_IDLE;
                        idx_nxt_s   = 2'd0;
                        assy_nxt_s  = 32'd0;
                    end else begin
                        mem_read_s  = rd_s;
                        mem_write_s = req_write;
                        mem_func3_s = F3_B;
                        mem_addr_s  = byte_addr_s;
                        mem_wdata_s = {24'd0, wbyte_s};
                        if (idx_r == last_idx(req_func3)) begin
                            rdata_en_s  = rd_s;
                            ext_word_s  = assy_cur_s;
                            ext_func3_s = req_func3;
                            state_nxt_s = ST_IDLE;
                            idx_nxt_s   = 2'd0;
                            assy_nxt_s  = 32'd0;
                        end else begin
                            stall_s   = 1'b1;
                            idx_nxt_s = idx_r + 2'd1;
                            if (rd_s) begin
                                assy_nxt_s = assy_cur_s;
                            end else begin
                                assy_nxt_s = assy_r;
                            end
                        end
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    idx_nxt_s   = 2'd0;
                    assy_nxt_s  = 32'd0;
                end
            endcase
        end
    end

    mem_load_ext u_load_ext (
        .word   (ext_word_s),
        .func3  (ext_func3_s),
        .result (ext_out_s)
    );

    // Load result is only driven in the cycle a load actually completes.
    always_comb begin
        if (rdata_en_s) begin
            rdata = ext_out_s;
        end else begin
            rdata = 32'd0;
        end
    end

    // Sequencer state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            idx_r   <= 2'd0;
            assy_r  <= 32'd0;
        end else begin
            state_r <= state_nxt_s;
            idx_r   <= idx_nxt_s;
            assy_r  <= assy_nxt_s;
        end
    end

    assign stall            = stall_s;
    assign misaligned_fault = fault_s;
    assign mem.MemRead      = mem_read_s;
    assign mem.MemWrite     = mem_write_s;
    assign mem.func3        = mem_func3_s;
    assign mem.addr         = mem_addr_s;
    assign mem.data_in      = mem_wdata_s;

endmodule

// File: tb/tb_misaligned_mem_seq.sv
// Scoreboard bench for misaligned_mem_seq against a byte-array data memory model.
module tb_misaligned_mem_seq;
    import misaligned_mem_seq_pkg::*;

    typedef struct {
        logic [31:0] rdata;
        int          cycles;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        req_read, req_write;
    logic [2:0]  req_func3;
    logic [31:0] req_addr, req_wdata;
    logic [31:0] rdata;
    logic        stall, fault;
    logic        r2_read;
    logic [2:0]  r2_func3;
    logic [31:0] r2_addr;
    logic [31:0] rdata2;
    logic        stall2, fault2;

    logic [7:0]  mem [0:1023];
    logic [31:0] mrd;
    logic [9:0]  ma;
    exp_t        exp_q[$];
    int          tests_run;
    int          tests_failed;

    misaligned_mem_seq_if #(.ADDR_W(32)) bus  ();
    misaligned_mem_seq_if #(.ADDR_W(32)) bus2 ();

    misaligned_mem_seq #(.ALLOW_MISALIGNED(1'b1), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .req_read(req_read), .req_write(req_write),
        .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rdata(rdata), .stall(stall), .misaligned_fault(fault), .mem(bus.master)
    );

    misaligned_mem_seq #(.ALLOW_MISALIGNED(1'b0), .ADDR_W(32)) dut_nomis (
        .clk(clk), .rst(rst), .req_read(r2_read), .req_write(1'b0),
        .req_func3(r2_func3), .req_addr(r2_addr), .req_wdata(32'd0),
        .rdata(rdata2), .stall(stall2), .misaligned_fault(fault2), .mem(bus2.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: combinational reads, byte/half/word writes on the clock edge.
    assign ma = bus.addr[9:0];
    always_comb begin
        mrd = 32'd0;
        if (bus.MemRead) begin
            case (bus.func3)
                3'd0: mrd = {{24{mem[ma][7]}}, mem[ma]};
                3'd4: mrd = {24'd0, mem[ma]};
                3'd1: mrd = {{16{mem[ma+10'd1][7]}}, mem[ma+10'd1], mem[ma]};
                3'd5: mrd = {16'd0, mem[ma+10'd1], mem[ma]};
                3'd2: mrd = {mem[ma+10'd3], mem[ma+10'd2], mem[ma+10'd1], mem[ma]};
                default: mrd = 32'd0;
            endcase
        end
    end
    assign bus.mem_rdata  = mrd;
    assign bus2.mem_rdata = bus2.MemRead ? 32'hCAFE0000 : 32'd0;

    always @(posedge clk) begin
        if (bus.MemWrite) begin
            case (bus.func3)
                3'd0: mem[ma] <= bus.data_in[7:0];
                3'd1: begin
                    mem[ma]       <= bus.data_in[7:0];
                    mem[ma+10'd1] <= bus.data_in[15:8];
                end
                3'd2: begin
                    mem[ma]       <= bus.data_in[7:0];
                    mem[ma+10'd1] <= bus.data_in[15:8];
                    mem[ma+10'd2] <= bus.data_in[23:16];
                    mem[ma+10'd3] <= bus.data_in[31:24];
                end
                default: ;
            endcase
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Drive one request and follow it until stall drops, checking the bus each cycle.
    task automatic run_access(input logic r, input logic w, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] exp_rd, input int exp_cyc);
        exp_t        e;
        int          cyc;
        bit          done;
        logic [31:0] got_rd;
        e.rdata  = exp_rd;
        e.cycles = exp_cyc;
        exp_q.push_back(e);
        req_read = r; req_write = w; req_func3 = f3; req_addr = a; req_wdata = wd;
        cyc = 0; done = 1'b0; got_rd = 32'hxxxxxxxx;
        while (!done && cyc < 8) begin
            @(negedge clk);
            cyc++;
            if (w) check_val("memread_forced_low", {31'd0, bus.MemRead}, 32'd0);
            if (exp_cyc > 1 && cyc <= exp_cyc) begin
                check_val("split_func3", {29'd0, bus.func3}, {29'd0, F3_B});
                check_val("split_addr", bus.addr, a + 32'(cyc - 1));
                if (w) check_val("split_wbyte", {24'd0, bus.data_in[7:0]}, {24'd0, wd[8*(cyc-1) +: 8]});
            end else if (exp_cyc == 1) begin
                check_val("pass_func3", {29'd0, bus.func3}, {29'd0, f3});
                check_val("pass_addr", bus.addr, a);
            end
            if (!stall) begin
                done   = 1'b1;
                got_rd = rdata;
            end
            @(posedge clk); #1;
        end
        e = exp_q.pop_front();
        if (!done) check_val("stall_timeout", {31'd0, stall}, 32'd0);
        check_val("latency", cyc, e.cycles);
        check_val("rdata", got_rd, e.rdata);
        req_read = 1'b0; req_write = 1'b0;
    endtask

    initial begin
        tests_run = 0; tests_failed = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        mem[0] = 8'd17;
        rst = 1'b1;
        req_read = 1'b0; req_write = 1'b0; req_func3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
        r2_read = 1'b0; r2_func3 = 3'd0; r2_addr = 32'd0;
        @(negedge clk);
        check_val("rst_stall", {31'd0, stall}, 32'd0);
        check_val("rst_memread", {31'd0, bus.MemRead}, 32'd0);
        check_val("rst_memwrite", {31'd0, bus.MemWrite}, 32'd0);
        check_val("rst_fault", {31'd0, fault2}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_access(1'b1, 1'b0, F3_W,  32'h000, 32'd0,        32'd17,        1);
        run_access(1'b0, 1'b1, F3_W,  32'h101, 32'hDEADBEEF, 32'd0,         4);
        check_val("mem_101", {24'd0, mem[10'h101]}, 32'h000000EF);
        check_val("mem_104", {24'd0, mem[10'h104]}, 32'h000000DE);
        run_access(1'b1, 1'b0, F3_W,  32'h101, 32'd0,        32'hDEADBEEF,  4);
        run_access(1'b1, 1'b0, F3_H,  32'h103, 32'd0,        32'hFFFFDEAD,  2);
        run_access(1'b1, 1'b0, F3_HU, 32'h103, 32'd0,        32'h0000DEAD,  2);
        run_access(1'b1, 1'b0, F3_H,  32'h102, 32'd0,        32'hFFFFADBE,  1);
        run_access(1'b1, 1'b0, F3_B,  32'h104, 32'd0,        32'hFFFFFFDE,  1);
        run_access(1'b1, 1'b0, F3_BU, 32'h104, 32'd0,        32'h000000DE,  1);
        run_access(1'b1, 1'b1, F3_H,  32'h201, 32'h00001234, 32'd0,         2);
        check_val("mem_201", {24'd0, mem[10'h201]}, 32'h00000034);
        check_val("mem_202", {24'd0, mem[10'h202]}, 32'h00000012);

        // Reset lands in the second cycle of a split store.
        req_write = 1'b1; req_func3 = F3_W; req_addr = 32'h301; req_wdata = 32'h11223344;
        @(negedge clk);
        check_val("rst_split_addr", bus.addr, 32'h301);
        check_val("rst_split_byte", {24'd0, bus.data_in[7:0]}, 32'h00000044);
        check_val("rst_split_stall", {31'd0, stall}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check_val("rst_cycle_memwrite", {31'd0, bus.MemWrite}, 32'd0);
        check_val("rst_cycle_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; req_write = 1'b0;
        @(negedge clk);
        check_val("post_rst_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        check_val("mem_301", {24'd0, mem[10'h301]}, 32'h00000044);
        check_val("mem_302", {24'd0, mem[10'h302]}, 32'h00000000);
        run_access(1'b1, 1'b0, F3_W, 32'h300, 32'd0, 32'h00004400, 1);

        // Request dropped after the first byte of a split load.
        req_read = 1'b1; req_func3 = F3_W; req_addr = 32'h105;
        @(negedge clk);
        check_val("drop_first_stall", {31'd0, stall}, 32'd1);
        @(posedge clk); #1;
        req_read = 1'b0;
        @(negedge clk);
        check_val("drop_stall", {31'd0, stall}, 32'd0);
        check_val("drop_memread", {31'd0, bus.MemRead}, 32'd0);
        check_val("drop_rdata", rdata, 32'd0);
        @(posedge clk); #1;
        run_access(1'b1, 1'b0, F3_W, 32'h000, 32'd0, 32'd17, 1);

        // Suppressing variant: misaligned lw faults for exactly one cycle.
        r2_read = 1'b1; r2_func3 = F3_W; r2_addr = 32'h2;
        @(negedge clk);
        check_val("nomis_fault", {31'd0, fault2}, 32'd1);
        check_val("nomis_memread", {31'd0, bus2.MemRead}, 32'd0);
        check_val("nomis_rdata", rdata2, 32'd0);
        check_val("nomis_stall", {31'd0, stall2}, 32'd0);
        @(posedge clk); #1;
        r2_read = 1'b0;
        @(negedge clk);
        check_val("nomis_fault_clear", {31'd0, fault2}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
